instr_sequencer: RTL and testbench

Multi-cycle fetch/issue sequencer for the basic processor. Owns the program counter, starts execution on a `Start` pulse, advances or redirects the PC from the control decoder's `jump_en`, stalls issue for the data-memory load latency, and stops on a decoded halt. It sits between the instruction ROM address port and the control decoder. Its `issue` and `load_done` outputs gate every architectural write (register file, data memory) downstream.

---
 rtl/instr_sequencer.sv | 130 +++++++++++++
 tb/tb_instr_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/issue sequencer.
// Owns the program counter, starts on a Start pulse, advances or redirects the PC
// from the decoder's jump request, stalls issue for the load latency and stops on halt.
//
// Ports:
//   Clk, Reset_n            clock (rising edge), asynchronous active-low reset
//   Start, start_addr       begin execution at start_addr (sampled in IDLE/DONE only)
//   jump_en, jump_target    decoder redirect request for the current instruction
//   ReadMem, WriteMem, halt decoder class of the current instruction
//   PC                      registered instruction ROM address
//   issue                   instruction at PC executes this cycle
//   load_done               one-cycle pulse: load write-back happens this cycle
//   busy, Done              RUN/LOAD_WAIT and DONE status
//   instr_count             saturating retired-instruction count since last Start
module instr_sequencer #(
    parameter int unsigned PC_W     = 10,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [PC_W-1:0]  start_addr,
    input  logic             jump_en,
    input  logic [PC_W-1:0]  jump_target,
    input  logic             ReadMem,
    input  logic             WriteMem,
    input  logic             halt,
    output logic [PC_W-1:0]  PC,
    output logic             issue,
    output logic             load_done,
    output logic             busy,
    output logic             Done,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StLoadWait,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       wait_q, wait_d;
    logic             retire;

    // Stores never stall and are not otherwise consumed here.
    logic unused_write_mem;
    assign unused_write_mem = WriteMem;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        retire  = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (Start) begin
                    pc_d    = start_addr;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (halt) begin
                    retire  = 1'b1;
                    state_d = StDone;
                end else if (ReadMem && (LOAD_LAT > 1)) begin
                    wait_d  = 4'(LOAD_LAT - 1);
                    state_d = StLoadWait;
                end else if (ReadMem) begin
                    retire = 1'b1;
                    pc_d   = pc_q + PC_W'(1);
                end else if (jump_en) begin
                    retire = 1'b1;
                    pc_d   = jump_target;
                end else begin
                    retire = 1'b1;
                    pc_d   = pc_q + PC_W'(1);
                end
            end
            StLoadWait: begin
                wait_d = wait_q - 4'd1;
                if (wait_q == 4'd1) begin
                    retire  = 1'b1;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
        // The retire of the first instruction after Start cannot coincide with the clear.
        if (retire && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        PC          = pc_q;
        instr_count = cnt_q;
        issue       = (state_q == StRun);
        busy        = (state_q == StRun) || (state_q == StLoadWait);
        Done        = (state_q == StDone);
        load_done   = (state_q == StLoadWait) && (wait_q == 4'd1);
        // Single-cycle loads write back in their own issue cycle, so the pulse must
        // follow the decoded load (halt takes priority over it).
        if (LOAD_LAT == 1) begin
            load_done = (state_q == StRun) && ReadMem && !halt;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: two instances (default parameters, and a narrow
// PC_W=4 / LOAD_LAT=1 / CNT_W=4 variant) driven by shared stimulus and compared
// each cycle against a behavioural model of the sequencer.
module tb_instr_sequencer;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic [9:0]  start_addr = '0;
    logic        jump_en = 1'b0;
    logic [9:0]  jump_target = '0;
    logic        ReadMem = 1'b0;
    logic        WriteMem = 1'b0;
    logic        halt = 1'b0;

    logic [9:0]  pc0;
    logic        issue0, ld0, busy0, done0;
    logic [15:0] cnt0;
    logic [3:0]  pc1;
    logic        issue1, ld1, busy1, done1;
    logic [3:0]  cnt1;

    int n_total = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    instr_sequencer dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .start_addr(start_addr),
        .jump_en(jump_en), .jump_target(jump_target), .ReadMem(ReadMem),
        .WriteMem(WriteMem), .halt(halt), .PC(pc0), .issue(issue0),
        .load_done(ld0), .busy(busy0), .Done(done0), .instr_count(cnt0)
    );

    instr_sequencer #(.PC_W(4), .LOAD_LAT(1), .CNT_W(4)) dut_s (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .start_addr(start_addr[3:0]),
        .jump_en(jump_en), .jump_target(jump_target[3:0]), .ReadMem(ReadMem),
        .WriteMem(WriteMem), .halt(halt), .PC(pc1), .issue(issue1),
        .load_done(ld1), .busy(busy1), .Done(done1), .instr_count(cnt1)
    );

    // Model: 0 idle, 1 run, 2 waiting on a load, 3 done.
    int m_st[2];
    int m_pc[2];
    int m_cnt[2];
    int m_left[2];

    function automatic int pc_mod(int i);
        return (i == 0) ? 1024 : 16;
    endfunction
    function automatic int lat(int i);
        return (i == 0) ? 2 : 1;
    endfunction
    function automatic int cnt_max(int i);
        return (i == 0) ? 65535 : 15;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_pc[i] = 0; m_cnt[i] = 0; m_left[i] = 0;
        end
    endtask

    task automatic model_retire(int i);
        if (m_cnt[i] < cnt_max(i)) m_cnt[i] = m_cnt[i] + 1;
    endtask

    // Effect of one rising edge with the current inputs.
    task automatic model_step(int i);
        case (m_st[i])
            0, 3: if (Start) begin
                m_pc[i] = int'(start_addr) % pc_mod(i);
                m_cnt[i] = 0;
                m_st[i] = 1;
            end
            1: begin
                if (halt) begin
                    model_retire(i);
                    m_st[i] = 3;
                end else if (ReadMem && lat(i) > 1) begin
                    m_left[i] = lat(i) - 1;
                    m_st[i] = 2;
                end else begin
                    if (jump_en && !ReadMem) m_pc[i] = int'(jump_target) % pc_mod(i);
                    else m_pc[i] = (m_pc[i] + 1) % pc_mod(i);
                    model_retire(i);
                end
            end
            default: begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) begin
                    m_pc[i] = (m_pc[i] + 1) % pc_mod(i);
                    model_retire(i);
                    m_st[i] = 1;
                end
            end
        endcase
    endtask

    function automatic logic exp_ld(int i);
        return (m_st[i] == 2 && m_left[i] == 1) ||
               (lat(i) == 1 && m_st[i] == 1 && ReadMem && !halt);
    endfunction

    task automatic check_all();
        check_eq("pc0", 32'(pc0), m_pc[0]);
        check_eq("issue0", 32'(issue0), 32'(m_st[0] == 1));
        check_eq("busy0", 32'(busy0), 32'(m_st[0] == 1 || m_st[0] == 2));
        check_eq("done0", 32'(done0), 32'(m_st[0] == 3));
        check_eq("load_done0", 32'(ld0), 32'(exp_ld(0)));
        check_eq("count0", 32'(cnt0), m_cnt[0]);
        check_eq("pc1", 32'(pc1), m_pc[1]);
        check_eq("issue1", 32'(issue1), 32'(m_st[1] == 1));
        check_eq("busy1", 32'(busy1), 32'(m_st[1] == 1 || m_st[1] == 2));
        check_eq("done1", 32'(done1), 32'(m_st[1] == 3));
        check_eq("load_done1", 32'(ld1), 32'(exp_ld(1)));
        check_eq("count1", 32'(cnt1), m_cnt[1]);
    endtask

    // Inputs are already driven; advance one edge and compare at the falling edge.
    task automatic cycle();
        if (!Reset_n) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
        @(posedge Clk);
        @(negedge Clk);
        check_all();
    endtask

    task automatic drive(input logic st, input int addr, input logic je, input int jt,
                         input logic rm, input logic hl);
        Start = st; start_addr = 10'(addr); jump_en = je; jump_target = 10'(jt);
        ReadMem = rm; halt = hl; WriteMem = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_all();
        Reset_n = 1'b1;

        // Start, run one instruction, then async reset mid-run.
        drive(1, 5, 0, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0); cycle();
        check_eq("run_pc_before_reset", 32'(pc0), 32'd6);
        #2 Reset_n = 1'b0;
        #1 model_reset();
        check_eq("async_pc", 32'(pc0), 32'd0);
        check_eq("async_issue", 32'(issue0), 32'd0);
        check_eq("async_done", 32'(done0), 32'd0);
        check_all();
        @(negedge Clk);
        Reset_n = 1'b1;

        // Start at 5: four plain instructions, halt at 9.
        drive(1, 5, 0, 0, 0, 0); cycle();
        check_eq("start_pc", 32'(pc0), 32'd5);
        check_eq("start_issue", 32'(issue0), 32'd1);
        check_eq("start_busy", 32'(busy0), 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        repeat (4) cycle();
        check_eq("seq_pc9", 32'(pc0), 32'd9);
        drive(0, 0, 0, 0, 0, 1); cycle();
        check_eq("halt_done", 32'(done0), 32'd1);
        check_eq("halt_pc", 32'(pc0), 32'd9);
        check_eq("halt_count", 32'(cnt0), 32'd5);
        drive(0, 0, 0, 0, 0, 0); cycle();
        check_eq("done_hold_pc", 32'(pc0), 32'd9);

        // Restart from DONE at 6, jump to 0x040, then jump+load takes the stall.
        drive(1, 6, 0, 0, 0, 0); cycle();
        check_eq("restart_count", 32'(cnt0), 32'd0);
        drive(0, 0, 1, 'h040, 0, 0); cycle();
        check_eq("jump_pc", 32'(pc0), 32'h040);
        check_eq("jump_count", 32'(cnt0), 32'd1);
        drive(0, 0, 1, 'h123, 1, 0); cycle();
        check_eq("jump_load_pc", 32'(pc0), 32'h040);
        check_eq("jump_load_issue", 32'(issue0), 32'd0);
        drive(0, 0, 0, 0, 0, 0); cycle();
        check_eq("after_load_pc", 32'(pc0), 32'h041);

        // Load at 10 with Start pulsed during the stall.
        drive(0, 0, 0, 0, 0, 1); cycle();
        drive(1, 10, 0, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 1, 0); cycle();
        check_eq("stall_issue", 32'(issue0), 32'd0);
        check_eq("stall_load_done", 32'(ld0), 32'd1);
        check_eq("stall_pc", 32'(pc0), 32'd10);
        drive(1, 'h123, 0, 0, 0, 0); cycle();
        check_eq("post_stall_pc", 32'(pc0), 32'd11);
        check_eq("post_stall_issue", 32'(issue0), 32'd1);

        // PC wrap.
        drive(0, 0, 0, 0, 0, 1); cycle();
        drive(1, 'h3FD, 0, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) cycle();
        check_eq("wrap_pc", 32'(pc0), 32'd0);

        // Restart at 0 from DONE, then 20 retires saturate the narrow counter.
        drive(0, 0, 0, 0, 0, 1); cycle();
        drive(1, 0, 0, 0, 0, 0); cycle();
        check_eq("restart0_pc", 32'(pc0), 32'd0);
        check_eq("restart0_count", 32'(cnt0), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        repeat (20) cycle();
        check_eq("sat_count_narrow", 32'(cnt1), 32'd15);
        check_eq("sat_count_wide", 32'(cnt0), 32'd20);

        // Reset just after entering LOAD_WAIT: the pending write-back is dropped.
        drive(0, 0, 0, 0, 1, 0);
        @(posedge Clk);
        #1 Reset_n = 1'b0;
        #1 model_reset();
        check_eq("wait_reset_load_done", 32'(ld0), 32'd0);
        check_eq("wait_reset_pc", 32'(pc0), 32'd0);
        @(negedge Clk);
        check_all();
        Reset_n = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            Start       = ($urandom % 8) == 0;
            start_addr  = 10'($urandom);
            jump_en     = ($urandom % 4) == 0;
            jump_target = 10'($urandom);
            ReadMem     = ($urandom % 5) == 0;
            WriteMem    = ($urandom % 5) == 0;
            halt        = ($urandom % 25) == 0;
            if (!Reset_n) Reset_n = 1'b1;
            else if (($urandom % 300) == 0) begin
                Reset_n = 1'b0;
                #1 model_reset();
                check_all();
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
